// File: rtl/fpu_int2float.sv
// ============================================================================
//  Module      : fpu_int2float
//  Description : Multi-cycle converter from a 32-bit signed two's-complement
//                integer to the packed float format
//                {sign[31], exp[30:25] (bias BIAS), frac[24:0] (hidden 1)}.
//                The magnitude is normalised one bit per cycle, then rounded
//                to nearest, ties to even.
//  Ports       : clock100KHz - clock, rising edge
//                reset       - synchronous, active-low reset
//                start       - conversion request, sampled only while idle
//                int_in      - signed integer operand, sampled with start
//                busy        - high while a conversion is in flight
//                done        - one-cycle pulse, result valid from this cycle
//                data_out    - packed float result
//                status_out  - one-hot: 0001 exact, 0010 inexact
//                              (0100 overflow / 1000 underflow never occur)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_int2float #(
    parameter int BIAS = 31
) (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] int_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2
    } state_t;

    // A magnitude with its MSB at bit 31 has unbiased exponent 31.
    localparam logic [5:0] c_EXP_INIT   = 6'(BIAS + 31);
    localparam logic [3:0] c_ST_EXACT   = 4'b0001;
    localparam logic [3:0] c_ST_INEXACT = 4'b0010;

    state_t      state_q, state_d;
    logic        sign_q;
    logic [31:0] mag_q;
    logic [5:0]  exp_q;
    logic        zero_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] data_q;
    logic [3:0]  status_q;

    logic [31:0] w_mag_in;
    logic [24:0] w_frac;
    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic [25:0] w_frac_sum;
    logic [24:0] w_frac_rnd;
    logic [5:0]  w_exp_rnd;

    // Two's-complement negate; 0x80000000 maps onto 2^31, which fits unsigned.
    assign w_mag_in = int_in[31] ? (~int_in + 32'd1) : int_in;

    // Rounding on the normalised magnitude (bit 31 is the hidden one).
    assign w_frac     = mag_q[30:6];
    assign w_guard    = mag_q[5];
    assign w_sticky   = |mag_q[4:0];
    assign w_round_up = w_guard & (w_sticky | w_frac[0]);
    assign w_frac_sum = {1'b0, w_frac} + 26'(w_round_up);
    // A carry out of the fraction leaves it zero and bumps the exponent.
    assign w_frac_rnd = w_frac_sum[24:0];
    assign w_exp_rnd  = exp_q + 6'(w_frac_sum[25]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (int_in == 32'd0) ? S_ROUND : S_NORM;
                end
            end
            S_NORM: begin
                if (mag_q[31]) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock100KHz) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            mag_q    <= 32'd0;
            exp_q    <= 6'd0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= 32'd0;
            status_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            // busy follows the state being entered, so it drops in the done cycle.
            busy_q  <= (state_d != S_IDLE);
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sign_q <= int_in[31];
                        mag_q  <= w_mag_in;
                        exp_q  <= c_EXP_INIT;
                        zero_q <= (int_in == 32'd0);
                    end
                end
                S_NORM: begin
                    if (!mag_q[31]) begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - 6'd1;
                    end
                end
                S_ROUND: begin
                    data_q   <= zero_q ? 32'd0 : {sign_q, w_exp_rnd, w_frac_rnd};
                    status_q <= (w_guard | w_sticky) ? c_ST_INEXACT : c_ST_EXACT;
                    done_q   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign data_out   = data_q;
    assign status_out = status_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_int2float.sv
// ============================================================================
//  Module      : tb_fpu_int2float
//  Description : Self-checking bench for fpu_int2float. Expected results are
//                queued when a conversion is launched and compared when done
//                pulses (data, status and latency).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fpu_int2float;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] int_in;
    logic        busy;
    logic        done;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        int          lat;
        int          start_cyc;
    } sb_entry_t;

    sb_entry_t sb[$];
    sb_entry_t mon_e;
    int        cyc;
    int        n_checks;
    int        n_errors;

    fpu_int2float #(.BIAS(31)) u_dut (
        .clock100KHz (clk),
        .reset       (reset),
        .start       (start),
        .int_in      (int_in),
        .busy        (busy),
        .done        (done),
        .data_out    (data_out),
        .status_out  (status_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference conversion written from the format definition.
    task automatic model(input logic [31:0] v, output logic [31:0] d,
                         output logic [3:0] s, output int lat);
        logic [31:0] mag;
        logic [31:0] norm;
        logic [24:0] frac;
        logic        g;
        logic        st;
        int          p;
        int          e;
        if (v == 32'd0) begin
            d = 32'd0; s = 4'b0001; lat = 2;
            return;
        end
        mag = v[31] ? (32'd0 - v) : v;
        p = 31;
        while (!mag[p]) p--;
        norm = mag << (31 - p);
        frac = norm[30:6];
        g    = norm[5];
        st   = |norm[4:0];
        e    = 31 + p;
        if (g && (st || frac[0])) begin
            if (&frac) begin
                frac = 25'd0;
                e++;
            end else begin
                frac = frac + 25'd1;
            end
        end
        d   = {v[31], 6'(e), frac};
        s   = (g || st) ? 4'b0010 : 4'b0001;
        lat = (31 - p) + 3;
    endtask

    // Call at a negedge: start is accepted on the following rising edge.
    task automatic conv(input logic [31:0] v, input logic [31:0] ed,
                        input logic [3:0] es, input int el);
        sb_entry_t e;
        e.d = ed; e.s = es; e.lat = el; e.start_cyc = cyc;
        sb.push_back(e);
        start  = 1'b1;
        int_in = v;
        @(posedge clk);
        #1;
        start  = 1'b0;
        int_in = $urandom;
    endtask

    // Returns at the negedge where done is observed high.
    task automatic wait_done;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("data_out", data_out, mon_e.d);
                check("status_out", {28'd0, status_out}, {28'd0, mon_e.s});
                check("latency", 32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
            end
        end
    end

    initial begin
        logic [31:0] rv;
        logic [31:0] ed;
        logic [3:0]  es;
        int          el;

        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        start    = 1'b0;
        int_in   = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_status", {28'd0, status_out}, 32'd0);

        // Directed cases.
        @(negedge clk); conv(32'd1,        32'h3E000000, 4'b0001, 34); wait_done();
        @(negedge clk); conv(32'hFFFFFFFF, 32'hBE000000, 4'b0001, 34); wait_done();
        @(negedge clk); conv(32'h80000000, 32'hFC000000, 4'b0001, 3);  wait_done();
        @(negedge clk); conv(32'd0,        32'h00000000, 4'b0001, 2);  wait_done();
        @(negedge clk); conv(32'h7FFFFFFF, 32'h7C000000, 4'b0010, 4);  wait_done();
        @(negedge clk); conv(32'h04000001, 32'h72000000, 4'b0010, 8);  wait_done();
        @(negedge clk); conv(32'h04000003, 32'h72000002, 4'b0010, 8);  wait_done();

        // Outputs hold after done.
        repeat (3) @(negedge clk);
        check("hold_data", data_out, 32'h72000002);

        // start while busy is ignored.
        @(negedge clk); conv(32'd1, 32'h3E000000, 4'b0001, 34);
        repeat (4) @(negedge clk);
        check("busy_mid", {31'd0, busy}, 32'd1);
        start  = 1'b1;
        int_in = 32'd5;
        @(negedge clk);
        start  = 1'b0;
        wait_done();

        // Back-to-back: start in the done cycle.
        check("busy_in_done", {31'd0, busy}, 32'd0);
        conv(32'd2, 32'h40000000, 4'b0001, 33);
        wait_done();

        // Random operands across the whole leading-zero range.
        for (int i = 0; i < 12; i++) begin
            rv = 32'($urandom) >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) rv = 32'd0 - rv;
            model(rv, ed, es, el);
            @(negedge clk);
            conv(rv, ed, es, el);
            wait_done();
        end

        // Reset in the middle of normalisation abandons the conversion.
        @(negedge clk); conv(32'd1, 32'h3E000000, 4'b0001, 34);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_data", data_out, 32'd0);
        check("midrst_status", {28'd0, status_out}, 32'd0);
        repeat (40) @(negedge clk);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fpu_int2float.md
Name: fpu_int2float

Overview:
- Multi-cycle converter from a 32-bit signed two's-complement integer to the team's 32-bit float format: sign [31], exponent [30:25] with bias 31, fraction [24:0] with an implicit leading 1.
- Acts as the operand-producing end of the float datapath: software or a testbench supplies integers, and this block produces packed operands for the adder's op_A_in/op_B_in.
- Status encoding is the same as the adder's.
- Start/done handshake; normalisation shifts one bit per cycle.

Parameters:
- BIAS, 31, exponent bias. Value = (-1)^s * 1.f * 2^(e-BIAS). The word 0x00000000 encodes zero.

Ports:
- clock100KHz  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request a conversion; sampled only in IDLE.
- int_in  in  32  signed integer operand; sampled on the edge that accepts start.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse; data_out and status_out are valid from this cycle.
- data_out  out  32  packed float result {sign, exp[5:0], frac[24:0]}.
- status_out  out  4  one-hot status: 0001 exact, 0010 inexact, 0100 overflow, 1000 underflow.

Behaviour:
- Reset (reset low at a rising edge, including mid-conversion):
  - state goes to IDLE.
  - busy=0, done=0, data_out=0, status_out=0000.
  - Internal mag/exp/sign registers are cleared.
  - Any conversion in progress is abandoned and produces no done pulse.
- Internal registers: sign (1), mag (32 unsigned), exp (6), zero flag.
- FSM states: IDLE, NORM, ROUND.
- IDLE:
  - done is driven 0 except in the cycle right after a completion.
  - If start=1: latch sign=int_in[31] and mag=|int_in| (two's-complement negate when negative; 0x80000000 gives mag=2^31). Set exp=62.
  - If int_in==0: set zero=1 and go to ROUND. Otherwise set zero=0 and go to NORM.
- NORM:
  - If mag[31]=1, go to ROUND.
  - Otherwise mag<=mag<<1, exp<=exp-1, stay in NORM.
  - The number of cycles spent here is L+1, where L = leading zeros of the magnitude (0..31).
- ROUND:
  - Field extraction: frac=mag[30:6], guard=mag[5], sticky=|mag[4:0].
  - Round to nearest, ties to even: round up when guard & (sticky | frac[0]).
  - If frac is all ones and rounds up: frac becomes 0 and exp becomes exp+1.
  - On this edge register: data_out={sign,exp,frac} (or 0x00000000 when zero=1), done<=1, then go to IDLE.
  - status_out = 0010 if guard|sticky, else 0001.
  - Overflow (0100) and underflow (1000) cannot arise, since the maximum exp is 62 and the minimum is 31. These codes are never driven.
- Latency, with the start-accepting edge counted as edge 1:
  - Nonzero input: done is high after edge L+3.
  - Zero input: done is high after edge 2.
- busy is a registered function of state. It is 0 during the done cycle, so start in the done cycle is accepted (back-to-back throughput).
- start while busy=1 is ignored; it is neither queued nor able to corrupt the active conversion. int_in is don't-care outside the accepting edge.
- data_out and status_out hold their last values until the next ROUND edge or reset.
- Sign is preserved for every nonzero input. Zero always yields +0 (0x00000000).

Test Plan:
- Reset held low 3 cycles, then released -> busy=0, done=0, data_out=0x00000000, status_out=0000. Assert reset low mid-NORM -> no done pulse, outputs return to zero.
- int_in=1 -> data_out=0x3E000000, status 0001, done after edge 34. int_in=-1 (0xFFFFFFFF) -> 0xBE000000, status 0001.
- int_in=0x80000000 -> 0xFC000000, status 0001, done after edge 3. int_in=0 -> 0x00000000, status 0001, done after edge 2.
- int_in=0x7FFFFFFF -> rounding carries out: data_out=0x7C000000, status 0010.
- Ties-to-even: 0x04000001 -> 0x72000000 (tie kept even), status 0010. 0x04000003 -> 0x72000002 (rounded up), status 0010.
- Handshake: pulse start with a new int_in while busy -> ignored, first result unchanged. Assert start in the done cycle with int_in=2 -> accepted, result 0x40000000.
